// File: rtl/demux_stream.sv
// Registered 1-to-N_CH stream demultiplexer with per-channel one-entry output registers.
// Optional DEMUX_STREAM_DROP_CNT_EN adds a saturating drop_cnt for invalid-select beats.
`timescale 1ns/1ps
module demux_stream #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
`ifdef DEMUX_STREAM_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     sel_err
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // in_ready never looks at in_valid, and the producer holds its beat until accepted.

  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  logic [N_CH-1:0] can_take;
  logic [N_CH-1:0] load;
  logic            sel_bad;
  logic            sel_take;
  logic            accept;
  logic            drop;

  always_comb begin
    can_take = ~out_valid | out_ready;
    sel_bad  = !in_bcast && ({1'b0, in_sel} >= N_CH_W);
    sel_take = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_take = can_take[k];
    end

    // Broadcast waits for every channel so a beat is never partially delivered.
    if (in_bcast)     in_ready = &can_take;
    else if (sel_bad) in_ready = 1'b1;
    else              in_ready = sel_take;

    accept = in_valid & in_ready;
    drop   = accept & sel_bad;
    load   = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept & (in_bcast | (!sel_bad && (in_sel == SEL_W'(k))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (load[k]) begin
          out_valid[k]                  <= 1'b1;
          out_data[k*DATA_W +: DATA_W]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_STREAM_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign sel_err = (drop_cnt != 16'd0);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sel_err <= 1'b0;
    else if (drop) sel_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel instance checked through per-channel expected
// queues drained by a monitor, plus a 5-channel instance for invalid-select handling.
`timescale 1ns/1ps
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 4-channel instance
  logic        iv, ir, ibc, serr;
  logic [7:0]  idata;
  logic [1:0]  isel;
  logic [3:0]  ov, ordy;
  logic [31:0] od;
  // 5-channel instance
  logic        iv5, ir5, ibc5, serr5;
  logic [7:0]  idata5;
  logic [2:0]  isel5;
  logic [4:0]  ov5, ordy5;
  logic [39:0] od5;
`ifdef DEMUX_STREAM_DROP_CNT_EN
  logic [15:0] dcnt, dcnt5;
`endif

  demux_stream #(.DATA_W(8), .N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(idata),
    .in_sel(isel), .in_bcast(ibc), .out_valid(ov), .out_ready(ordy), .out_data(od),
`ifdef DEMUX_STREAM_DROP_CNT_EN
    .drop_cnt(dcnt),
`endif
    .sel_err(serr)
  );

  demux_stream #(.DATA_W(8), .N_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .in_data(idata5),
    .in_sel(isel5), .in_bcast(ibc5), .out_valid(ov5), .out_ready(ordy5), .out_data(od5),
`ifdef DEMUX_STREAM_DROP_CNT_EN
    .drop_cnt(dcnt5),
`endif
    .sel_err(serr5)
  );

  logic [7:0] exp_q[4][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat to the 4-channel DUT and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] sel, input logic bc, input logic [7:0] d,
                      input bit expect_no_stall);
    int waited = 0;
    bit done = 1'b0;
    iv = 1'b1; isel = sel; ibc = bc; idata = d;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (ir) begin
        if (bc) for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
        else    exp_q[sel].push_back(d);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'(done), 64'd1);
    if (expect_no_stall) chk("no_stall", 64'(waited), 64'd0);
  endtask

  // Monitor: each beat taken by a consumer must match the oldest expected beat for that lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && ordy[k]) begin
          if (exp_q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, od[k*8 +: 8]);
          end else begin
            chk($sformatf("ch%0d_data", k), 64'(od[k*8 +: 8]), 64'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    iv = 0; isel = 0; ibc = 0; idata = 0; ordy = 0;
    iv5 = 0; isel5 = 0; ibc5 = 0; idata5 = 0; ordy5 = 0;
    #12;
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_data", 64'(od), 64'd0);
    chk("rst_sel_err", 64'(serr), 64'd0);
    for (int s = 0; s < 4; s++) begin
      isel = 2'(s);
      #1 chk("rst_in_ready_uni", 64'(ir), 64'd1);
      ibc = 1'b1;
      #1 chk("rst_in_ready_bcast", 64'(ir), 64'd1);
      ibc = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    step();

    // Unicast into channel 2, then a second beat blocked by the full channel
    send(2'd2, 1'b0, 8'hA5, 1'b1);
    iv = 1'b0;
    chk("uni_out_valid", 64'(ov), 64'b0100);
    chk("uni_lane2", 64'(od[23:16]), 64'hA5);
    iv = 1'b1; isel = 2'd2; idata = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("uni_blocked", 64'(ir), 64'd0);
    end
    @(posedge clk);
    #1 ordy[2] = 1'b1;
    send(2'd2, 1'b0, 8'h5A, 1'b1);
    iv = 1'b0;
    step();
    ordy = 4'b0000;
    chk("uni_drained", 64'(ov), 64'd0);

    // Broadcast blocked by full channel 1 until its consumer is ready
    send(2'd1, 1'b0, 8'h11, 1'b1);
    iv = 1'b0;
    iv = 1'b1; ibc = 1'b1; idata = 8'h3C;
    repeat (2) begin
      @(negedge clk);
      chk("bcast_blocked", 64'(ir), 64'd0);
    end
    @(posedge clk);
    #1 ordy[1] = 1'b1;
    send(2'd0, 1'b1, 8'h3C, 1'b1);
    iv = 1'b0; ibc = 1'b0; ordy = 4'b0000;
    chk("bcast_out_valid", 64'(ov), 64'hF);
    chk("bcast_out_data", 64'(od), 64'h3C3C3C3C);
    ordy = 4'hF;
    step();
    step();
    chk("bcast_drained", 64'(ov), 64'd0);

    // Back-to-back stream into channel 0 with an always-ready consumer
    ordy = 4'b0001;
    for (int i = 1; i <= 16; i++) send(2'd0, 1'b0, 8'(i), 1'b1);
    iv = 1'b0;
    step();
    step();
    ordy = 4'b0000;

    // 5-channel instance: invalid selects are swallowed and flagged
    iv5 = 1'b1; isel5 = 3'd6; idata5 = 8'hEE;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("badsel_in_ready", 64'(ir5), 64'd1);
      step();
      chk("badsel_no_valid", 64'(ov5), 64'd0);
      chk("badsel_sel_err", 64'(serr5), 64'd1);
    end
    iv5 = 1'b0;
`ifdef DEMUX_STREAM_DROP_CNT_EN
    chk("drop_cnt_3", 64'(dcnt5), 64'd3);
`endif
    iv5 = 1'b1; isel5 = 3'd4; idata5 = 8'h44;
    @(negedge clk);
    chk("ch4_in_ready", 64'(ir5), 64'd1);
    step();
    iv5 = 1'b0;
    chk("ch4_out_valid", 64'(ov5), 64'b10000);
    chk("ch4_lane", 64'(od5[39:32]), 64'h44);
    chk("sel_err_sticky", 64'(serr5), 64'd1);

    // Reset while channels 0 and 3 hold beats
    send(2'd0, 1'b0, 8'hC0, 1'b1);
    send(2'd3, 1'b0, 8'hC3, 1'b1);
    iv = 1'b0;
    chk("pre_rst_valid", 64'(ov), 64'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov), 64'd0);
    chk("midrst_sel_err", 64'(serr), 64'd0);
    chk("midrst_out_valid5", 64'(ov5), 64'd0);
    chk("midrst_sel_err5", 64'(serr5), 64'd0);
`ifdef DEMUX_STREAM_DROP_CNT_EN
    chk("midrst_drop_cnt5", 64'(dcnt5), 64'd0);
`endif
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Post-reset traffic to the last channel
    ordy = 4'hF;
    send(2'd3, 1'b0, 8'h7E, 1'b1);
    iv = 1'b0;
    step();
    step();
    chk("pow2_sel_err", 64'(serr), 64'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("queue%0d_empty", k), 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
